// File: rtl/reg_wb_sched.sv
// Write-back scheduler: arbitrates the register-file write port between ALU and
// load results and tracks outstanding loads for RAW hazard detection.
module reg_wb_sched #(
  parameter  int DEPTH = 16,
  localparam int WIDTH = 64,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [ADDRW-1:0] alu_addr,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [ADDRW-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             ld_issue,
  input  logic [ADDRW-1:0] ld_addr,
  input  logic [ADDRW-1:0] q0_addr,
  input  logic [ADDRW-1:0] q1_addr,
  output logic             q0_busy,
  output logic             q1_busy,
  output logic             rf_en,
  output logic [ADDRW-1:0] rf_addr,
  output logic [WIDTH-1:0] rf_data,
  output logic             sb_err
);

  localparam logic [ADDRW-1:0] ZERO_ADDR = {ADDRW{1'b0}};
  localparam logic [DEPTH-1:0] ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

  logic             prio_r;      // 0: ALU wins a tie, 1: MEM wins a tie
  logic             prio_nxt_s;
  logic             alu_gnt_s;
  logic             mem_gnt_s;
  logic             wr_en_s;
  logic [ADDRW-1:0] wr_addr_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [DEPTH-1:0] set_mask_s;
  logic [DEPTH-1:0] clr_mask_s;
  logic             err_s;

  // Grant selection and round-robin priority update
  always_comb begin
    alu_gnt_s  = 1'b0;
    mem_gnt_s  = 1'b0;
    prio_nxt_s = prio_r;
    if (alu_valid && mem_valid) begin
      alu_gnt_s  = ~prio_r;
      mem_gnt_s  = prio_r;
      prio_nxt_s = ~prio_r;
    end else begin
      alu_gnt_s  = alu_valid;
      mem_gnt_s  = mem_valid;
    end
  end

  assign alu_ready = alu_gnt_s;
  assign mem_ready = mem_gnt_s;

  // Select the granted write; register 0 is hardwired so such writes are dropped
  always_comb begin
    wr_addr_s = alu_addr;
    wr_data_s = alu_data;
    if (mem_gnt_s) begin
      wr_addr_s = mem_addr;
      wr_data_s = mem_data;
    end else begin
      wr_addr_s = alu_addr;
      wr_data_s = alu_data;
    end
    wr_en_s = (alu_gnt_s || mem_gnt_s) && (wr_addr_s != ZERO_ADDR);
  end

  // Scoreboard next state: a new load marking wins over a same-cycle load return
  always_comb begin
    set_mask_s = (ld_issue && (ld_addr != ZERO_ADDR)) ? (ONE_HOT0 << ld_addr) : {DEPTH{1'b0}};
    clr_mask_s = mem_gnt_s ? (ONE_HOT0 << mem_addr) : {DEPTH{1'b0}};
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
    err_s      = ld_issue && (ld_addr != ZERO_ADDR) && pend_r[ld_addr]
                 && !(mem_gnt_s && (mem_addr == ld_addr));
  end

  // Priority, scoreboard and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
      pend_r <= {DEPTH{1'b0}};
      sb_err <= 1'b0;
    end else begin
      prio_r <= prio_nxt_s;
      pend_r <= pend_nxt_s;
      sb_err <= sb_err | err_s;
    end
  end

  // Registered write stage toward the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en   <= 1'b0;
      rf_addr <= ZERO_ADDR;
      rf_data <= {WIDTH{1'b0}};
    end else begin
      rf_en <= wr_en_s;
      if (wr_en_s) begin
        rf_addr <= wr_addr_s;
        rf_data <= wr_data_s;
      end
    end
  end

  // A write still sitting in the rf stage is not yet visible in the register file
  assign q0_busy = (q0_addr != ZERO_ADDR) && (pend_r[q0_addr] || (rf_en && (rf_addr == q0_addr)));
  assign q1_busy = (q1_addr != ZERO_ADDR) && (pend_r[q1_addr] || (rf_en && (rf_addr == q1_addr)));

endmodule
